// File: rtl/msrv32_pkg.sv
// Shared RV32I encoding constants: immediate-format selectors, major opcodes
// and the request bundle carried through the instruction encoder pipeline.
package msrv32_pkg;

    localparam logic [2:0] IMM_R    = 3'd0;
    localparam logic [2:0] IMM_I    = 3'd1;
    localparam logic [2:0] IMM_S    = 3'd2;
    localparam logic [2:0] IMM_B    = 3'd3;
    localparam logic [2:0] IMM_U    = 3'd4;
    localparam logic [2:0] IMM_J    = 3'd5;
    localparam logic [2:0] IMM_CSR  = 3'd6;
    localparam logic [2:0] IMM_RSVD = 3'd7;

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_REG    = 7'b0110011;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_SYSTEM = 7'b1110011;

    typedef struct packed {
        logic [2:0]  imm_type;
        logic [31:0] imm;
        logic [6:0]  opcode;
        logic [4:0]  rd;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [2:0]  funct3;
        logic [6:0]  funct7;
    } enc_req_t;

    // True when v is a sign extension of its low 'bits' bits.
    function automatic logic fits_signed(input logic [31:0] v, input int unsigned bits);
        logic [31:0] hi;
        hi = $signed(v) >>> (bits - 1);
        return (hi == '0) || (hi == '1);
    endfunction

endpackage

// File: rtl/msrv32_imm_scatter.sv
// Combinational scatter of an immediate into its RV32I format, plus a flag
// raised when the immediate does not fit the chosen format.
module msrv32_imm_scatter
    import msrv32_pkg::*;
(
    input  enc_req_t    req,
    output logic [31:0] instr,
    output logic        err
);

    always_comb begin
        // NOTE: every output gets a default first so no path through the case infers a latch.
        instr = {req.imm[11:0], req.rs1, req.funct3, req.rd, req.opcode};
        err   = !fits_signed(req.imm, 12);
        case (req.imm_type)
            IMM_R: begin
                instr = {req.funct7, req.rs2, req.rs1, req.funct3, req.rd, req.opcode};
                err   = 1'b0;
            end
            IMM_S: begin
                instr = {req.imm[11:5], req.rs2, req.rs1, req.funct3, req.imm[4:0], req.opcode};
            end
            IMM_B: begin
                instr = {req.imm[12], req.imm[10:5], req.rs2, req.rs1, req.funct3,
                         req.imm[4:1], req.imm[11], req.opcode};
                err   = !fits_signed(req.imm, 13) || req.imm[0];
            end
            IMM_U: begin
                instr = {req.imm[31:12], req.rd, req.opcode};
                err   = |req.imm[11:0];
            end
            IMM_J: begin
                instr = {req.imm[20], req.imm[10:1], req.imm[11], req.imm[19:12],
                         req.rd, req.opcode};
                err   = !fits_signed(req.imm, 21) || req.imm[0];
            end
            IMM_CSR: begin
                // CSR addresses are zero-extended, so any upper bit is an error.
                err   = |req.imm[31:12];
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/msrv32_instr_encoder.sv
// Two-stage valid/ready pipeline around the immediate scatter: S1 captures the
// request, S2 holds the encoded word and its error flag; counts accepted requests.
module msrv32_instr_encoder
    import msrv32_pkg::*;
#(
    parameter int CNT_W = 16
) (
    input  logic             ms_riscv32_mp_clk_in,
    input  logic             ms_riscv32_mp_rst_in,
    input  logic             valid_in,
    output logic             ready_out,
    input  logic [2:0]       imm_type_in,
    input  logic [31:0]      imm_in,
    input  logic [6:0]       opcode_in,
    input  logic [4:0]       rd_in,
    input  logic [4:0]       rs1_in,
    input  logic [4:0]       rs2_in,
    input  logic [2:0]       funct3_in,
    input  logic [6:0]       funct7_in,
    output logic             valid_out,
    input  logic             ready_in,
    output logic [31:0]      instr_out,
    output logic             imm_err_out,
    output logic [CNT_W-1:0] count_out
);

    logic             s1_valid;
    enc_req_t         s1_req;
    logic             s2_valid;
    logic [31:0]      s2_instr;
    logic             s2_err;
    logic [CNT_W-1:0] count;
    logic [31:0]      enc_instr;
    logic             enc_err;
    logic             s2_ready;
    logic             in_fire;

    assign s2_ready  = !s2_valid || ready_in;
    assign ready_out = !s1_valid || s2_ready;
    assign in_fire   = valid_in && ready_out;

    msrv32_imm_scatter u_scatter (
        .req   (s1_req),
        .instr (enc_instr),
        .err   (enc_err)
    );

    always_ff @(posedge ms_riscv32_mp_clk_in) begin
        if (!ms_riscv32_mp_rst_in) begin
            s1_valid <= 1'b0;
            s2_valid <= 1'b0;
            s2_instr <= '0;
            s2_err   <= 1'b0;
            count    <= '0;
        end else begin
            if (ready_out) s1_valid <= valid_in;
            if (s2_ready) begin
                s2_valid <= s1_valid;
                // Only a real word may replace S2 data, so outputs never show a bubble's contents.
                if (s1_valid) begin
                    s2_instr <= enc_instr;
                    s2_err   <= enc_err;
                end
            end
            if (in_fire) count <= count + CNT_W'(1);
        end
    end

    // NOTE: S1 payload is deliberately not reset; s1_valid alone qualifies it.
    always_ff @(posedge ms_riscv32_mp_clk_in) begin
        if (in_fire) begin
            s1_req <= '{imm_type: imm_type_in, imm: imm_in, opcode: opcode_in,
                        rd: rd_in, rs1: rs1_in, rs2: rs2_in,
                        funct3: funct3_in, funct7: funct7_in};
        end
    end

    assign valid_out   = s2_valid;
    assign instr_out   = s2_instr;
    assign imm_err_out = s2_err;
    assign count_out   = count;

endmodule

// File: tb/tb_msrv32_instr_encoder.sv
// Self-checking bench: directed RV32I encodings, backpressure, mid-stream reset
// and randomized traffic against an arithmetic reference model and scoreboard.
module tb_msrv32_instr_encoder;
    import msrv32_pkg::*;

    typedef struct {
        logic [31:0] instr;
        logic        err;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        valid_in, ready_out, valid_out, ready_in, imm_err_out;
    logic [2:0]  imm_type_in, funct3_in;
    logic [31:0] imm_in, instr_out;
    logic [6:0]  opcode_in, funct7_in;
    logic [4:0]  rd_in, rs1_in, rs2_in;
    logic [15:0] count_out;

    int          vectors = 0;
    int          miscompares = 0;
    exp_t        exp_q[$];
    exp_t        cur_exp;
    logic [15:0] model_cnt = '0;
    logic        last_acc;

    always #5 clk = ~clk;

    msrv32_instr_encoder #(.CNT_W(16)) dut (
        .ms_riscv32_mp_clk_in (clk),
        .ms_riscv32_mp_rst_in (rst_n),
        .valid_in             (valid_in),
        .ready_out            (ready_out),
        .imm_type_in          (imm_type_in),
        .imm_in               (imm_in),
        .opcode_in            (opcode_in),
        .rd_in                (rd_in),
        .rs1_in               (rs1_in),
        .rs2_in               (rs2_in),
        .funct3_in            (funct3_in),
        .funct7_in            (funct7_in),
        .valid_out            (valid_out),
        .ready_in             (ready_in),
        .instr_out            (instr_out),
        .imm_err_out          (imm_err_out),
        .count_out            (count_out)
    );

    task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        vectors++;
        assert (observed === expected) else begin
            miscompares++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, observed, expected);
        end
    endtask

    // Reference encoder built from field positions and numeric ranges.
    function automatic exp_t ref_encode(input logic [2:0] t, input logic [31:0] imm,
                                        input logic [6:0] op, input logic [4:0] rd,
                                        input logic [4:0] rs1, input logic [4:0] rs2,
                                        input logic [2:0] f3, input logic [6:0] f7);
        exp_t        e;
        int          s;
        logic [31:0] base;
        s    = signed'(imm);
        base = 32'(op) | (32'(rd) << 7) | (32'(f3) << 12) | (32'(rs1) << 15);
        e.err = 1'b0;
        case (t)
            IMM_R: e.instr = base | (32'(rs2) << 20) | (32'(f7) << 25);
            IMM_S: begin
                e.instr = 32'(op) | ((imm & 32'h1F) << 7) | (32'(f3) << 12) | (32'(rs1) << 15)
                        | (32'(rs2) << 20) | (((imm >> 5) & 32'h7F) << 25);
                e.err = (s < -2048) || (s > 2047);
            end
            IMM_B: begin
                e.instr = 32'(op) | (((imm >> 11) & 32'h1) << 7) | (((imm >> 1) & 32'hF) << 8)
                        | (32'(f3) << 12) | (32'(rs1) << 15) | (32'(rs2) << 20)
                        | (((imm >> 5) & 32'h3F) << 25) | (((imm >> 12) & 32'h1) << 31);
                e.err = (s < -4096) || (s > 4095) || (imm % 2 != 0);
            end
            IMM_U: begin
                e.instr = (imm & 32'hFFFFF000) | 32'(op) | (32'(rd) << 7);
                e.err = (imm & 32'hFFF) != 0;
            end
            IMM_J: begin
                e.instr = 32'(op) | (32'(rd) << 7) | (((imm >> 12) & 32'hFF) << 12)
                        | (((imm >> 11) & 32'h1) << 20) | (((imm >> 1) & 32'h3FF) << 21)
                        | (((imm >> 20) & 32'h1) << 31);
                e.err = (s < -(1 << 20)) || (s >= (1 << 20)) || (imm % 2 != 0);
            end
            IMM_CSR: begin
                e.instr = base | ((imm & 32'hFFF) << 20);
                e.err = imm > 32'hFFF;
            end
            default: begin
                e.instr = base | ((imm & 32'hFFF) << 20);
                e.err = (s < -2048) || (s > 2047);
            end
        endcase
        return e;
    endfunction

    // One clock: sample away from the edge, then book accepts/drains into the scoreboard.
    task automatic cycle();
        logic acc, drn;
        #1;
        acc = rst_n && valid_in && ready_out;
        drn = rst_n && valid_out && ready_in;
        if (rst_n) begin
            check("count", 32'(count_out), 32'(model_cnt));
            if (valid_out) begin
                if (exp_q.size() == 0) check("spurious_valid", 32'(valid_out), 32'd0);
                else begin
                    check("instr", instr_out, exp_q[0].instr);
                    check("imm_err", 32'(imm_err_out), 32'(exp_q[0].err));
                end
            end
        end
        @(posedge clk);
        #1;
        last_acc = acc;
        if (!rst_n) begin
            exp_q.delete();
            model_cnt = '0;
        end else begin
            if (acc) begin
                exp_q.push_back(cur_exp);
                model_cnt++;
            end
            if (drn) void'(exp_q.pop_front());
        end
    endtask

    task automatic set_req(input logic [2:0] t, input logic [31:0] imm, input logic [6:0] op,
                           input logic [4:0] rd, input logic [4:0] rs1, input logic [4:0] rs2,
                           input logic [2:0] f3, input logic [6:0] f7);
        imm_type_in = t; imm_in = imm; opcode_in = op; rd_in = rd;
        rs1_in = rs1; rs2_in = rs2; funct3_in = f3; funct7_in = f7;
    endtask

    task automatic send_directed(input logic [2:0] t, input logic [31:0] imm, input logic [6:0] op,
                                 input logic [4:0] rd, input logic [4:0] rs1, input logic [4:0] rs2,
                                 input logic [2:0] f3, input logic [31:0] exp_instr, input logic exp_err);
        int n = 0;
        set_req(t, imm, op, rd, rs1, rs2, f3, 7'd0);
        cur_exp = '{instr: exp_instr, err: exp_err};
        valid_in = 1'b1;
        do begin
            cycle();
            n++;
        end while (!last_acc && n < 20);
        if (!last_acc) check("accept_timeout", 32'(last_acc), 32'd1);
        valid_in = 1'b0;
    endtask

    task automatic set_rand();
        logic [2:0] t;
        t = 3'($urandom_range(0, 7));
        case ($urandom_range(0, 4))
            0: imm_in = $urandom;
            1: imm_in = 32'($urandom_range(0, 8191)) - 32'd4096;
            2: imm_in = $urandom & 32'hFFFFF000;
            3: imm_in = 32'($urandom_range(0, 4095));
            default: imm_in = 32'($urandom_range(0, 4194303)) - 32'd2097152;
        endcase
        set_req(t, imm_in, 7'($urandom), 5'($urandom), 5'($urandom), 5'($urandom),
                3'($urandom), 7'($urandom));
        cur_exp = ref_encode(imm_type_in, imm_in, opcode_in, rd_in, rs1_in, rs2_in,
                             funct3_in, funct7_in);
    endtask

    task automatic drain();
        int n = 0;
        valid_in = 1'b0;
        ready_in = 1'b1;
        while (exp_q.size() != 0 && n < 20) begin
            cycle();
            n++;
        end
        check("drain_empty", 32'(exp_q.size()), 32'd0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        logic [15:0] base_cnt;
        logic        saw_stall_ready;
        int          sent;
        int          n;

        rst_n = 1'b0; valid_in = 1'b0; ready_in = 1'b1; last_acc = 1'b0;
        set_req(IMM_R, '0, '0, '0, '0, '0, '0, '0);
        cur_exp = '{instr: '0, err: 1'b0};
        cycle();
        cycle();
        check("rst_valid_out", 32'(valid_out), 32'd0);
        check("rst_instr_out", instr_out, 32'd0);
        check("rst_imm_err", 32'(imm_err_out), 32'd0);
        check("rst_count", 32'(count_out), 32'd0);
        rst_n = 1'b1;
        #1;
        check("rst_ready_out", 32'(ready_out), 32'd1);

        // Latency: accept in cycle 0, valid_out in cycle 2.
        set_req(IMM_I, 32'd5, OP_IMM, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0);
        cur_exp = '{instr: 32'h00500093, err: 1'b0};
        valid_in = 1'b1;
        cycle();
        check("lat_accept", 32'(last_acc), 32'd1);
        valid_in = 1'b0;
        #1 check("lat_cycle1_valid", 32'(valid_out), 32'd0);
        cycle();
        #1 check("lat_cycle2_valid", 32'(valid_out), 32'd1);
        drain();

        send_directed(IMM_S, 32'd8, OP_STORE, 5'd0, 5'd1, 5'd2, 3'd2, 32'h0020A423, 1'b0);
        send_directed(IMM_U, 32'hAABBC000, OP_LUI, 5'd5, 5'd0, 5'd0, 3'd0, 32'hAABBC2B7, 1'b0);
        send_directed(IMM_B, 32'hFFFFFFFC, OP_BRANCH, 5'd0, 5'd0, 5'd0, 3'd0, 32'hFE000EE3, 1'b0);
        send_directed(IMM_J, 32'h00000800, OP_JAL, 5'd1, 5'd0, 5'd0, 3'd0, 32'h001000EF, 1'b0);
        send_directed(IMM_I, 32'h00000800, OP_IMM, 5'd1, 5'd0, 5'd0, 3'd0, 32'h80000093, 1'b1);
        send_directed(IMM_B, 32'd3, OP_BRANCH, 5'd0, 5'd0, 5'd0, 3'd0, 32'h00000163, 1'b1);
        send_directed(IMM_U, 32'd1, OP_LUI, 5'd5, 5'd0, 5'd0, 3'd0, 32'h000002B7, 1'b1);
        drain();

        // Backpressure: five back-to-back requests, ready_in low in cycles 3..6.
        base_cnt = count_out;
        saw_stall_ready = 1'b0;
        sent = 0;
        for (int cyc = 1; cyc <= 40; cyc++) begin
            if (sent == 5 && exp_q.size() == 0) break;
            ready_in = !(cyc >= 3 && cyc <= 6);
            valid_in = (sent < 5);
            if (sent < 5) set_req(IMM_I, 32'(sent * 16 + 1), OP_IMM, 5'(sent + 1), 5'd3, 5'd0, 3'd0, 7'd0);
            cur_exp = ref_encode(imm_type_in, imm_in, opcode_in, rd_in, rs1_in, rs2_in, funct3_in, funct7_in);
            if (cyc == 3) begin
                #1 check("bp_ready_low_full", 32'(ready_out), 32'd0);
                saw_stall_ready = !ready_out;
            end
            cycle();
            if (last_acc) sent++;
        end
        valid_in = 1'b0;
        check("bp_ready_dropped", 32'(saw_stall_ready), 32'd1);
        check("bp_all_out", 32'(exp_q.size()), 32'd0);
        check("bp_count", 32'(count_out), 32'(base_cnt + 16'd5));

        // Randomized traffic with random valid_in / ready_in; a stalled request is held.
        valid_in = 1'b0;
        for (int i = 0; i < 400; i++) begin
            if (!valid_in || last_acc) begin
                set_rand();
                valid_in = ($urandom_range(0, 3) != 0);
            end
            ready_in = ($urandom_range(0, 3) != 0);
            cycle();
            if (last_acc) valid_in = 1'b0;
        end
        drain();

        // Reset with both stages full.
        ready_in = 1'b0;
        n = 0;
        while (ready_out && n < 10) begin
            set_rand();
            valid_in = 1'b1;
            cycle();
            n++;
        end
        valid_in = 1'b0;
        #1 check("full_before_rst", 32'(valid_out), 32'd1);
        rst_n = 1'b0;
        cycle();
        rst_n = 1'b1;
        #1;
        check("midrst_valid_out", 32'(valid_out), 32'd0);
        check("midrst_count", 32'(count_out), 32'd0);
        check("midrst_ready_out", 32'(ready_out), 32'd1);
        ready_in = 1'b1;
        for (int i = 0; i < 4; i++) begin
            cycle();
            check("midrst_no_stale", 32'(valid_out), 32'd0);
        end
        set_req(IMM_CSR, 32'h00000305, OP_SYSTEM, 5'd2, 5'd4, 5'd0, 3'd1, 7'd0);
        cur_exp = ref_encode(IMM_CSR, 32'h00000305, OP_SYSTEM, 5'd2, 5'd4, 5'd0, 3'd1, 7'd0);
        valid_in = 1'b1;
        cycle();
        drain();
        check("final_count", 32'(count_out), 32'd1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
